// File: rtl/ahb_response_mux_pkg.sv
// Shared AHB types for the data-phase return path: transfer/response encodings
// and the default-slave state enum.
package ahb_response_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_type;

  // Only NONSEQ and SEQ carry a real transfer; IDLE/BUSY complete with OKAY.
  function automatic logic is_active(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_response_mux_if.sv
// Bus bundle between decoder/slaves and the master-facing response mux.
interface ahb_response_mux_if
  import ahb_response_mux_pkg::*;
#(
  parameter int AHB_DATA_WIDTH     = 32,
  parameter int MASTER_X_SLAVE_NUM = 7
);

  logic [MASTER_X_SLAVE_NUM-1:0] hreq;
  logic                          default_slv_sel;
  htrans_type                    htrans;
  logic [AHB_DATA_WIDTH-1:0]     hrdata_slv [MASTER_X_SLAVE_NUM];
  hresp_type                     hresp_slv [MASTER_X_SLAVE_NUM];
  logic [MASTER_X_SLAVE_NUM-1:0] hreadyout_slv;
  logic [AHB_DATA_WIDTH-1:0]     hrdata;
  hresp_type                     hresp;
  logic                          hready;

  modport slave (
    input  hreq, default_slv_sel, htrans, hrdata_slv, hresp_slv, hreadyout_slv,
    output hrdata, hresp, hready
  );

  modport master (
    output hreq, default_slv_sel, htrans, hrdata_slv, hresp_slv, hreadyout_slv,
    input  hrdata, hresp, hready
  );

endinterface

// File: rtl/ahb_response_mux_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ accesses with the two-cycle
// AHB ERROR response; IDLE/BUSY to unmapped space complete as zero-wait OKAY.
module ahb_default_slave
  import ahb_response_mux_pkg::*;
(
  input  logic       hclk,
  input  logic       hreset,
  input  logic       hready,
  input  logic       default_slv_sel,
  input  htrans_type htrans,
  output logic       hreadyout_def,
  output hresp_type  hresp_def
);

  ds_state_type state_q;
  ds_state_type state_d;
  logic         new_err_s;

  assign new_err_s = hready & default_slv_sel & is_active(htrans);

  // State register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a fresh unmapped access in DS_ERR2 chains straight into DS_ERR1
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: begin
        if (new_err_s) begin
          state_d = DS_ERR1;
        end else begin
          state_d = DS_IDLE;
        end
      end
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: begin
        if (new_err_s) begin
          state_d = DS_ERR1;
        end else begin
          state_d = DS_IDLE;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Response outputs decoded from state only
  always_comb begin
    hreadyout_def = 1'b1;
    hresp_def     = OKAY;
    case (state_q)
      DS_IDLE: begin
        hreadyout_def = 1'b1;
        hresp_def     = OKAY;
      end
      DS_ERR1: begin
        hreadyout_def = 1'b0;
        hresp_def     = ERROR;
      end
      DS_ERR2: begin
        hreadyout_def = 1'b1;
        hresp_def     = ERROR;
      end
      default: begin
        hreadyout_def = 1'b1;
        hresp_def     = OKAY;
      end
    endcase
  end

endmodule

// File: rtl/ahb_response_mux.sv
// AHB data-phase return path: registers the decoder's slave select into the
// data phase and muxes the selected slave (or the default slave) to the master.
module ahb_response_mux
  import ahb_response_mux_pkg::*;
#(
  parameter int AHB_DATA_WIDTH     = 32,
  parameter int MASTER_X_SLAVE_NUM = 7
)(
  input logic               hclk,
  input logic               hreset,
  ahb_response_mux_if.slave bus
);

  localparam int SEL_IDX_W = (MASTER_X_SLAVE_NUM > 1) ? $clog2(MASTER_X_SLAVE_NUM) : 1;

  logic [MASTER_X_SLAVE_NUM-1:0] dsel_q;
  logic [MASTER_X_SLAVE_NUM-1:0] dsel_d;
  logic                          ddef_q;
  logic                          ddef_d;
  logic [SEL_IDX_W-1:0]          sel_idx_s;
  logic                          hreadyout_def_s;
  hresp_type                     hresp_def_s;
  logic                          hready_s;
  hresp_type                     hresp_s;
  logic [AHB_DATA_WIDTH-1:0]     hrdata_s;

  // Multi-hot select is illegal but must resolve deterministically: lowest index wins.
  function automatic logic [SEL_IDX_W-1:0] lowest_set_index(
    input logic [MASTER_X_SLAVE_NUM-1:0] vec
  );
    logic [SEL_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MASTER_X_SLAVE_NUM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = SEL_IDX_W'(i);
      end
    end
    return idx;
  endfunction

  ahb_default_slave u_default_slave (
    .hclk            (hclk),
    .hreset          (hreset),
    .hready          (hready_s),
    .default_slv_sel (bus.default_slv_sel),
    .htrans          (bus.htrans),
    .hreadyout_def   (hreadyout_def_s),
    .hresp_def       (hresp_def_s)
  );

  // Capture the address phase only when the bus advances
  always_comb begin
    dsel_d = dsel_q;
    ddef_d = ddef_q;
    if (hready_s) begin
      if (bus.default_slv_sel) begin
        dsel_d = '0;
      end else begin
        dsel_d = bus.hreq;
      end
      ddef_d = bus.default_slv_sel & is_active(bus.htrans);
    end else begin
      dsel_d = dsel_q;
      ddef_d = ddef_q;
    end
  end

  // Data-phase select registers
  always_ff @(posedge hclk) begin
    if (hreset) begin
      dsel_q <= '0;
      ddef_q <= 1'b0;
    end else begin
      dsel_q <= dsel_d;
      ddef_q <= ddef_d;
    end
  end

  assign sel_idx_s = lowest_set_index(dsel_q);

  // Response mux; with no data phase pending the bus reads ready/OKAY
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = OKAY;
    hrdata_s = '0;
    if (ddef_q) begin
      hready_s = hreadyout_def_s;
      hresp_s  = hresp_def_s;
      hrdata_s = '0;
    end else if (|dsel_q) begin
      hready_s = bus.hreadyout_slv[sel_idx_s];
      hresp_s  = bus.hresp_slv[sel_idx_s];
      hrdata_s = bus.hrdata_slv[sel_idx_s];
    end else begin
      hready_s = 1'b1;
      hresp_s  = OKAY;
      hrdata_s = '0;
    end
  end

  assign bus.hready = hready_s;
  assign bus.hresp  = hresp_s;
  assign bus.hrdata = hrdata_s;

endmodule
